// File: rtl/alu_arb_pkg.sv
// Shared definitions for the ALU share arbiter: opcodes, FSM state encoding, opcode legality.
// Latency: n/a (package only).
// Backpressure: n/a.
package alu_arb_pkg;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111;
   localparam logic [3:0] OP_NOR = 4'b1100;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   // True for the opcodes the ALU actually implements.
   function automatic logic op_is_legal(input logic [3:0] op);
      case (op)
         OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR: return 1'b1;
         default:                                      return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first asserted request at or after ptr, wrapping past NUM_REQ-1.
// Latency: purely combinational.
// Backpressure: none; caller decides when the grant is used.
module rr_arbiter #(
   parameter int NUM_REQ = 2
) (
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] ptr,
   output logic [NUM_REQ-1:0]         grant,
   output logic [$clog2(NUM_REQ)-1:0] idx,
   output logic                       any
);

   localparam int IDX_W = $clog2(NUM_REQ);

   logic [IDX_W:0]   sum;
   logic [IDX_W-1:0] cand;

   // Scan candidates in priority order starting from ptr; the first valid one wins.
   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      sum   = '0;
      cand  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         sum = {1'b0, ptr} + (IDX_W+1)'(k);
         if (sum >= (IDX_W+1)'(NUM_REQ)) begin
            sum = sum - (IDX_W+1)'(NUM_REQ);
         end
         cand = sum[IDX_W-1:0];
         if (!any && req[cand]) begin
            grant[cand] = 1'b1;
            idx         = cand;
            any         = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU among NUM_REQ requesters; round-robin accept, one settle cycle, tagged response.
// Latency: accept at edge N -> rsp_valid from cycle N+2 (N+1 for a rejected opcode); 1 op per 3 cycles peak.
// Backpressure: rsp_ready low holds the response stable; no new request is accepted until it drains.
// Optional opcode check enabled by defining ALU_ARB_OPCHK_EN.
module alu_share_arbiter
   import alu_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int DATA_W  = 32,
   parameter int OP_W    = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [NUM_REQ*OP_W-1:0]    req_op,
   input  logic [NUM_REQ*DATA_W-1:0]  req_data1,
   input  logic [NUM_REQ*DATA_W-1:0]  req_data2reg,
   input  logic [NUM_REQ*DATA_W-1:0]  req_data2ext,
   input  logic [NUM_REQ-1:0]         req_mux,
   output logic [OP_W-1:0]            alu_op,
   output logic [DATA_W-1:0]          alu_data1,
   output logic [DATA_W-1:0]          alu_data2reg,
   output logic [DATA_W-1:0]          alu_data2ext,
   output logic                       alu_mux,
   input  logic [DATA_W-1:0]          alu_result,
   input  logic                       alu_zero,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [$clog2(NUM_REQ)-1:0] rsp_id,
   output logic [DATA_W-1:0]          rsp_result,
   output logic                       rsp_zero,
   output logic                       rsp_err
);

   localparam int IDX_W = $clog2(NUM_REQ);

   logic [1:0]         state;
   logic [IDX_W-1:0]   rr_ptr;
   logic [IDX_W-1:0]   id_q;
   logic [NUM_REQ-1:0] grant;
   logic [IDX_W-1:0]   win_idx;
   logic               any_req;
   logic [OP_W-1:0]    win_op;
   logic               win_illegal;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .req   (req_valid),
      .ptr   (rr_ptr),
      .grant (grant),
      .idx   (win_idx),
      .any   (any_req)
   );

   assign win_op    = req_op[win_idx*OP_W +: OP_W];
   assign req_ready = (state == ST_IDLE) ? grant : '0;
   assign rsp_valid = (state == ST_RESP);
   assign rsp_id    = id_q;

`ifdef ALU_ARB_OPCHK_EN
   logic err_q;

   assign win_illegal = !op_is_legal(win_op);
   assign rsp_err     = err_q;

   // Error flag is decided at accept and held until the next accept.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if (state == ST_IDLE && any_req) begin
         err_q <= win_illegal;
      end
   end
`else
   assign win_illegal = 1'b0;
   assign rsp_err     = 1'b0;
`endif

   // Accept/execute/respond sequencing, operand latching and result capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         rr_ptr       <= '0;
         id_q         <= '0;
         alu_op       <= '0;
         alu_data1    <= '0;
         alu_data2reg <= '0;
         alu_data2ext <= '0;
         alu_mux      <= 1'b0;
         rsp_result   <= '0;
         rsp_zero     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (any_req) begin
                  id_q <= win_idx;
                  if (win_illegal) begin
                     // Rejected op never reaches the ALU; answer straight away with zeros.
                     rsp_result <= '0;
                     rsp_zero   <= 1'b0;
                     state      <= ST_RESP;
                  end else begin
                     alu_op       <= win_op;
                     alu_data1    <= req_data1[win_idx*DATA_W +: DATA_W];
                     alu_data2reg <= req_data2reg[win_idx*DATA_W +: DATA_W];
                     alu_data2ext <= req_data2ext[win_idx*DATA_W +: DATA_W];
                     alu_mux      <= req_mux[win_idx];
                     state        <= ST_EXEC;
                  end
               end
            end
            ST_EXEC: begin
               rsp_result <= alu_result;
               rsp_zero   <= alu_zero;
               state      <= ST_RESP;
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  state  <= ST_IDLE;
                  rr_ptr <= (id_q == IDX_W'(NUM_REQ-1)) ? '0 : id_q + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios then randomized transactions against a reference model.
// Latency: n/a.
// Backpressure: exercises stalled responses via rsp_ready.
module tb_alu_share_arbiter;

   localparam int N = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [N*4-1:0]  req_op;
   logic [N*32-1:0] req_data1, req_data2reg, req_data2ext;
   logic [N-1:0]    req_mux;
   logic [3:0]      alu_op;
   logic [31:0]     alu_data1, alu_data2reg, alu_data2ext;
   logic            alu_mux;
   logic [31:0]     alu_result;
   logic            alu_zero;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [0:0]      rsp_id;
   logic [31:0]     rsp_result;
   logic            rsp_zero;
   logic            rsp_err;

   // Requester-side stimulus, one entry per requester.
   logic        v   [N];
   logic [3:0]  op  [N];
   logic [31:0] d1  [N];
   logic [31:0] d2r [N];
   logic [31:0] d2e [N];
   logic        mx  [N];

   int checks = 0;
   int errors = 0;
   int ptr_m  = 0;   // model: requester with highest priority next

   logic [3:0] legal_ops [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};

   always #5 clk = ~clk;

   alu_share_arbiter #(.NUM_REQ(N), .DATA_W(32), .OP_W(4)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_data1(req_data1), .req_data2reg(req_data2reg), .req_data2ext(req_data2ext),
      .req_mux(req_mux),
      .alu_op(alu_op), .alu_data1(alu_data1), .alu_data2reg(alu_data2reg),
      .alu_data2ext(alu_data2ext), .alu_mux(alu_mux),
      .alu_result(alu_result), .alu_zero(alu_zero),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
   );

   function automatic logic [31:0] ref_alu(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
      case (o)
         4'b0000: return a & b;
         4'b0001: return a | b;
         4'b0010: return a + b;
         4'b0110: return a - b;
         4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'b1100: return ~(a | b);
         default: return 32'd0;
      endcase
   endfunction

   // Combinational ALU seen by the arbiter.
   always_comb begin
      alu_result = ref_alu(alu_op, alu_data1, alu_mux ? alu_data2ext : alu_data2reg);
      alu_zero   = (alu_result == 32'd0);
   end

   // Pack per-requester stimulus onto the flat buses.
   always_comb begin
      req_valid = '0; req_op = '0; req_data1 = '0; req_data2reg = '0; req_data2ext = '0; req_mux = '0;
      for (int i = 0; i < N; i++) begin
         req_valid[i]           = v[i];
         req_op[i*4 +: 4]       = op[i];
         req_data1[i*32 +: 32]  = d1[i];
         req_data2reg[i*32 +: 32] = d2r[i];
         req_data2ext[i*32 +: 32] = d2e[i];
         req_mux[i]             = mx[i];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Round-robin rule: first valid requester counting up from the priority pointer.
   function automatic int model_winner();
      for (int k = 0; k < N; k++) begin
         if (v[(ptr_m + k) % N]) return (ptr_m + k) % N;
      end
      return -1;
   endfunction

   task automatic set_req(input int i, input logic [3:0] o, input logic [31:0] a,
                          input logic [31:0] br, input logic [31:0] be, input logic m);
      v[i] = 1'b1; op[i] = o; d1[i] = a; d2r[i] = br; d2e[i] = be; mx[i] = m;
   endtask

   task automatic rand_req(input int i);
      set_req(i, legal_ops[$urandom_range(5)], $urandom, $urandom, $urandom, 1'($urandom_range(1)));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      ptr_m = 0;
   endtask

   // One complete request/response, entered just after a rising edge with requests already set up.
   task automatic txn(input int stall, input bit drop);
      int w;
      logic [3:0]  e_op;
      logic [31:0] e_d1, e_d2r, e_d2e, e_res;
      logic        e_mx;
      w = model_winner();
      if (w < 0) begin
         chk("txn_has_request", 32'd0, 32'd1);
         return;
      end
      e_op = op[w]; e_d1 = d1[w]; e_d2r = d2r[w]; e_d2e = d2e[w]; e_mx = mx[w];
      e_res = ref_alu(e_op, e_d1, e_mx ? e_d2e : e_d2r);
      rsp_ready = (stall == 0);
      @(negedge clk);
      chk("grant", 32'(req_ready), 32'(1 << w));
      chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
      @(posedge clk); #1;
      if (drop) v[w] = 1'b0;
      d1[w] = $urandom;   // operands after the accepting edge must not matter
      @(negedge clk);
      chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("exec_req_ready", 32'(req_ready), 32'd0);
      chk("alu_op", 32'(alu_op), 32'(e_op));
      chk("alu_data1", alu_data1, e_d1);
      chk("alu_data2reg", alu_data2reg, e_d2r);
      chk("alu_data2ext", alu_data2ext, e_d2e);
      chk("alu_mux", 32'(alu_mux), 32'(e_mx));
      @(negedge clk);
      chk("rsp_valid", 32'(rsp_valid), 32'd1);
      chk("rsp_id", 32'(rsp_id), 32'(w));
      chk("rsp_result", rsp_result, e_res);
      chk("rsp_zero", 32'(rsp_zero), 32'(e_res == 32'd0));
      chk("rsp_err", 32'(rsp_err), 32'd0);
      for (int s = 1; s <= stall; s++) begin
         @(posedge clk); #1;
         if (s == stall) rsp_ready = 1'b1;
         @(negedge clk);
         chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
         chk("stall_rsp_result", rsp_result, e_res);
         chk("stall_rsp_id", 32'(rsp_id), 32'(w));
         chk("stall_req_ready", 32'(req_ready), 32'd0);
      end
      @(posedge clk); #1;
      ptr_m = (w + 1) % N;
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         v[i] = 1'b0; op[i] = '0; d1[i] = '0; d2r[i] = '0; d2e[i] = '0; mx[i] = 1'b0;
      end
      rsp_ready = 1'b0;
      do_reset();

      // Reset state
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_result", rsp_result, 32'd0);
      chk("rst_rsp_id", 32'(rsp_id), 32'd0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);
      chk("rst_alu_op", 32'(alu_op), 32'd0);
      chk("rst_alu_data1", alu_data1, 32'd0);
      @(posedge clk); #1;

      // Single AND: 0F & 07 = 07
      set_req(0, 4'b0000, 32'h0F, 32'h07, 32'h0, 1'b0);
      txn(0, 1'b1);

      // Both valid from reset: ADD to requester 0 first, then SUB to requester 1
      do_reset();
      set_req(0, 4'b0010, 32'h0F, 32'h0F, 32'h0, 1'b0);
      set_req(1, 4'b0110, 32'h0F, 32'h0F, 32'h0, 1'b0);
      txn(0, 1'b1);
      txn(0, 1'b1);

      // Fairness: both held valid for six grants
      do_reset();
      rand_req(0);
      rand_req(1);
      for (int g = 0; g < 6; g++) begin
         chk("fair_order", 32'(model_winner()), 32'(g % 2));
         txn(0, 1'b0);
      end

      // Backpressure: requester 0 stalled 5 cycles while requester 1 waits
      txn(5, 1'b1);
      txn(0, 1'b1);

      // Immediate operand path: 5 + 3 via data2ext
      set_req(0, 4'b0010, 32'd5, 32'hFFFF_FFFF, 32'h0000_0003, 1'b1);
      txn(0, 1'b1);
      chk("imm_result", rsp_result, 32'd8);

      // Reset while in EXEC drops the op and returns priority to requester 0
      set_req(1, 4'b0010, 32'd1, 32'd2, 32'd0, 1'b0);
      @(negedge clk);
      chk("pre_rst_grant", 32'(req_ready), 32'd2);
      @(posedge clk); #1;
      v[1] = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      ptr_m = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("rst_drop_rsp_valid", 32'(rsp_valid), 32'd0);
         chk("rst_drop_req_ready", 32'(req_ready), 32'd0);
      end
      chk("rst_drop_alu_op", 32'(alu_op), 32'd0);
      @(posedge clk); #1;
      rand_req(0);
      rand_req(1);
      txn(0, 1'b1);
      txn(0, 1'b1);

`ifdef ALU_ARB_OPCHK_EN
      // Illegal opcode answers one cycle after accept with an error and zero result
      set_req(0, 4'b0011, 32'd9, 32'd9, 32'd9, 1'b0);
      rsp_ready = 1'b0;
      @(negedge clk);
      chk("ill_grant", 32'(req_ready), 32'd1);
      begin
         logic [31:0] prev_d1;
         prev_d1 = alu_data1;
         @(posedge clk); #1;
         v[0] = 1'b0;
         @(negedge clk);
         chk("ill_rsp_valid", 32'(rsp_valid), 32'd1);
         chk("ill_rsp_err", 32'(rsp_err), 32'd1);
         chk("ill_rsp_result", rsp_result, 32'd0);
         chk("ill_rsp_zero", 32'(rsp_zero), 32'd0);
         chk("ill_alu_data1", alu_data1, prev_d1);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      ptr_m = 1;
`endif

      // Randomized traffic
      for (int t = 0; t < 40; t++) begin
         for (int i = 0; i < N; i++) begin
            if (!v[i] && $urandom_range(1) == 1) rand_req(i);
         end
         if (model_winner() < 0) rand_req($urandom_range(N-1));
         txn($urandom_range(3), 1'($urandom_range(1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
